// File: rtl/ddr_burst_ctrl_pkg.sv
// Shared definitions for the rd_burst/wr_burst user interface and the MIG UI
// command encodings. Burst masters import this package too, so encodings
// live in one place.
package ddr_burst_ctrl_pkg;

    // Width of the rd/wr_burst_len fields (up to 1023 beats per burst).
    localparam int LEN_WIDTH = 10;

    // MIG UI app_cmd encodings.
    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    // Burst controller states. The numeric values are visible on the debug
    // port, so keep them stable.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEM_WRITE = 3'd1,
        ST_MEM_READ  = 3'd2,
        ST_WRITE_END = 3'd3,
        ST_READ_END  = 3'd4
    } burst_state_e;

endpackage

// File: rtl/ddr_burst_ctrl.sv
// Burst responder between user traffic masters and the MIG UI port.
// One read or write burst is served at a time. Each beat is one DATA_WIDTH
// word and one MIG command. Commands and write data are tracked by separate
// counters, so write data is allowed to run ahead of the commands.
//
// Handshake semantics:
//   - MIG command: app_en is a registered valid and app_rdy is the ready.
//     A command transfers on a cycle where app_en && app_rdy. While app_rdy
//     is low, app_en, app_addr and app_cmd are held unchanged.
//   - MIG write data: app_wdf_wren is valid and app_wdf_rdy is ready. wren is
//     only raised when app_wdf_rdy is already high, so every wren cycle is a
//     transfer. wr_burst_data_req mirrors it, and the master advances its
//     data on the following cycle.
//   - MIG read data: app_rd_data_valid has no backpressure. Every accepted
//     beat is registered and appears one cycle later on rd_burst_data_valid.
module ddr_burst_ctrl
    import ddr_burst_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_STEP  = 8
) (
    input  logic                    ui_clk,
    input  logic                    ui_clk_sync_rst,
    // read burst user port
    input  logic                    rd_burst_req,
    input  logic [LEN_WIDTH-1:0]    rd_burst_len,
    input  logic [ADDR_WIDTH-1:0]   rd_burst_addr,
    output logic                    rd_burst_data_valid,
    output logic [DATA_WIDTH-1:0]   rd_burst_data,
    output logic                    rd_burst_finish,
    // write burst user port
    input  logic                    wr_burst_req,
    input  logic [LEN_WIDTH-1:0]    wr_burst_len,
    input  logic [ADDR_WIDTH-1:0]   wr_burst_addr,
    output logic                    wr_burst_data_req,
    input  logic [DATA_WIDTH-1:0]   wr_burst_data,
    output logic                    wr_burst_finish,
    // MIG UI command port
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    // MIG UI write data port
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_rdy,
    // MIG UI read data port
    input  logic [DATA_WIDTH-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    // debug: current FSM state (burst_state_e encoding)
    output logic [2:0]              dbg_state_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    burst_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic [LEN_WIDTH-1:0]  data_cnt_q, data_cnt_d;
    logic [LEN_WIDTH-1:0]  cmd_cnt_inc;
    logic                  app_en_q, app_en_d;
    logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
    logic [2:0]            app_cmd_q, app_cmd_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic cmd_fire;
    logic wr_beat;
    logic rd_beat;
    logic burst_done;

    assign cmd_fire    = app_en_q && app_rdy;
    assign cmd_cnt_inc = cmd_cnt_q + 1'b1;
    assign wr_beat     = (state_q == ST_MEM_WRITE) && app_wdf_rdy && (data_cnt_q < len_q);
    assign rd_beat     = (state_q == ST_MEM_READ) && app_rd_data_valid && (data_cnt_q < len_q);
    assign burst_done  = (cmd_cnt_q == len_q) && (data_cnt_q == len_q);

    // Next-state logic for the FSM, counters and the registered command port.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cmd_cnt_d  = cmd_cnt_q;
        data_cnt_d = data_cnt_q;
        app_en_d   = app_en_q;
        app_addr_d = app_addr_q;
        app_cmd_d  = app_cmd_q;

        case (state_q)
            ST_IDLE: begin
                // A read has priority when both requests are present.
                if (rd_burst_req) begin
                    state_d    = ST_MEM_READ;
                    len_d      = rd_burst_len;
                    app_addr_d = rd_burst_addr;
                    app_cmd_d  = APP_CMD_RD;
                    app_en_d   = (rd_burst_len != '0);
                    cmd_cnt_d  = '0;
                    data_cnt_d = '0;
                end else if (wr_burst_req) begin
                    state_d    = ST_MEM_WRITE;
                    len_d      = wr_burst_len;
                    app_addr_d = wr_burst_addr;
                    app_cmd_d  = APP_CMD_WR;
                    app_en_d   = (wr_burst_len != '0);
                    cmd_cnt_d  = '0;
                    data_cnt_d = '0;
                end
            end

            ST_MEM_WRITE, ST_MEM_READ: begin
                // After a transfer, raise app_en again only if commands remain.
                // The address wraps naturally at the ADDR_WIDTH boundary.
                if (cmd_fire) begin
                    cmd_cnt_d  = cmd_cnt_inc;
                    app_addr_d = app_addr_q + STEP;
                    app_en_d   = (cmd_cnt_inc < len_q);
                end
                if (wr_beat || rd_beat) begin
                    data_cnt_d = data_cnt_q + 1'b1;
                end
                // A zero-length burst also takes this exit on its first cycle.
                if (burst_done) begin
                    state_d = (state_q == ST_MEM_WRITE) ? ST_WRITE_END : ST_READ_END;
                end
            end

            ST_WRITE_END, ST_READ_END: begin
                // Spend one idle cycle afterwards so the master can drop its request.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and command-port registers. Reset aborts any burst in flight.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cmd_cnt_q  <= '0;
            data_cnt_q <= '0;
            app_en_q   <= 1'b0;
            app_addr_q <= '0;
            app_cmd_q  <= APP_CMD_RD;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cmd_cnt_q  <= cmd_cnt_d;
            data_cnt_q <= data_cnt_d;
            app_en_q   <= app_en_d;
            app_addr_q <= app_addr_d;
            app_cmd_q  <= app_cmd_d;
        end
    end

    // Register read data toward the master. Beats outside an active read are dropped.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_beat;
            rd_data_q  <= app_rd_data;
        end
    end

    assign app_en              = app_en_q;
    assign app_addr            = app_addr_q;
    assign app_cmd             = app_cmd_q;

    assign wr_burst_data_req   = wr_beat;
    assign app_wdf_wren        = wr_beat;
    assign app_wdf_end         = wr_beat;
    assign app_wdf_data        = wr_burst_data;
    assign app_wdf_mask        = '0;

    assign rd_burst_data_valid = rd_valid_q;
    assign rd_burst_data       = rd_data_q;

    assign wr_burst_finish     = (state_q == ST_WRITE_END);
    assign rd_burst_finish     = (state_q == ST_READ_END);

    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
// Testbench for ddr_burst_ctrl. It contains:
//   - a behavioural MIG model with random app_rdy/app_wdf_rdy stalls and
//     4-20 cycle in-order read latency;
//   - a table of bursts with hand-computed command counts and last addresses;
//   - hand-written sequences for simultaneous requests, zero-length timing
//     and reset during a read.
module tb_ddr_burst_ctrl;
    import ddr_burst_ctrl_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;

    // ---------------- clock / reset ----------------
    logic ui_clk = 1'b0;
    logic rst;
    always #5 ui_clk = ~ui_clk;

    // ---------------- DUT signals ----------------
    logic                 rd_burst_req, wr_burst_req;
    logic [LEN_WIDTH-1:0] rd_burst_len, wr_burst_len;
    logic [AW-1:0]        rd_burst_addr, wr_burst_addr;
    logic                 rd_burst_data_valid, rd_burst_finish;
    logic [DW-1:0]        rd_burst_data;
    logic                 wr_burst_data_req, wr_burst_finish;
    logic [DW-1:0]        wr_burst_data;
    logic [AW-1:0]        app_addr;
    logic [2:0]           app_cmd;
    logic                 app_en, app_rdy;
    logic [DW-1:0]        app_wdf_data;
    logic                 app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [DW/8-1:0]      app_wdf_mask;
    logic [DW-1:0]        app_rd_data;
    logic                 app_rd_data_valid;
    logic [2:0]           dbg_state;

    ddr_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_STEP(8)) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (rst),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .dbg_state_o         (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [AW+2:0] exp_cmd_q[$];   // {app_cmd, app_addr}
    logic [DW-1:0] exp_wdata_q[$];
    logic [DW-1:0] exp_rdata_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    int      n_cmd, n_wbeat, n_rbeat, n_wfin, n_rfin;
    logic [AW-1:0] last_addr;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [DW-1:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected no event", name, act);
    endtask

    // ---------------- MIG behavioural model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_pend_t;

    rd_pend_t      pend_q[$];
    logic [DW-1:0] mig_mem [logic [AW-1:0]];
    logic [AW-1:0] mig_waddr_q[$];
    logic [DW-1:0] mig_wdata_q[$];
    int            cycle    = 0;
    int            last_due = 0;
    logic [DW-1:0] wr_base;
    int            wr_beat_idx;

    // Drive the MIG-side inputs and write data just after each rising edge.
    initial begin
        app_rdy           = 1'b0;
        app_wdf_rdy       = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        wr_burst_data     = '0;
        forever begin
            @(posedge ui_clk);
            #1;
            cycle++;
            app_rdy     = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 4) != 0);
            if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
            end
            wr_burst_data = wr_base + DW'(wr_beat_idx);
        end
    end

    // Observe transfers on the falling edge and score them.
    logic          prev_pending = 1'b0;
    logic [AW-1:0] prev_addr    = '0;
    initial begin
        logic [AW+2:0] e_cmd;
        logic [DW-1:0] e_dat;
        logic [AW-1:0] wa;
        int            due;
        forever begin
            @(negedge ui_clk);
            if (rst) begin
                prev_pending = 1'b0;
            end else begin
                // a stalled command must be held unchanged
                if (prev_pending) begin
                    check("app_en_hold", DW'(app_en), DW'(1'b1));
                    check("app_addr_hold", DW'(app_addr), DW'(prev_addr));
                end
                prev_pending = app_en && !app_rdy;
                prev_addr    = app_addr;

                if (app_en && app_rdy) begin
                    n_cmd++;
                    last_addr = app_addr;
                    if (exp_cmd_q.size() == 0) begin
                        flag("unexpected_cmd", DW'({app_cmd, app_addr}));
                    end else begin
                        e_cmd = exp_cmd_q.pop_front();
                        check("cmd_addr", DW'({app_cmd, app_addr}), DW'(e_cmd));
                    end
                    if (app_cmd == APP_CMD_RD) begin
                        due = cycle + 1 + int'($urandom_range(4, 20));
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        pend_q.push_back('{due: due,
                            data: (mig_mem.exists(app_addr) ? mig_mem[app_addr] : '0)});
                    end else begin
                        mig_waddr_q.push_back(app_addr);
                    end
                end

                if (wr_burst_data_req || app_wdf_wren || app_wdf_end) begin
                    check("wdf_strobes", DW'({app_wdf_wren, app_wdf_end}), DW'({2{wr_burst_data_req}}));
                end
                if (wr_burst_data_req) begin
                    n_wbeat++;
                    if (exp_wdata_q.size() == 0) begin
                        flag("unexpected_wdata", app_wdf_data);
                    end else begin
                        e_dat = exp_wdata_q.pop_front();
                        check("wdata", app_wdf_data, e_dat);
                    end
                    mig_wdata_q.push_back(app_wdf_data);
                    wr_beat_idx++;
                end
                while (mig_waddr_q.size() > 0 && mig_wdata_q.size() > 0) begin
                    wa = mig_waddr_q.pop_front();
                    mig_mem[wa] = mig_wdata_q.pop_front();
                end

                if (rd_burst_data_valid) begin
                    n_rbeat++;
                    if (exp_rdata_q.size() == 0) begin
                        flag("unexpected_rdata", rd_burst_data);
                    end else begin
                        e_dat = exp_rdata_q.pop_front();
                        check("rdata", rd_burst_data, e_dat);
                    end
                end
                if (wr_burst_finish) n_wfin++;
                if (rd_burst_finish) n_rfin++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        bit            is_rd;
        int            len;
        logic [AW-1:0] addr;
        logic [DW-1:0] base;      // write data of beat i is base + i
        int            exp_ncmd;
        logic [AW-1:0] exp_last;  // address of the last command
    } vec_t;

    vec_t vecs[8];

    task automatic clear_counts();
        n_cmd = 0; n_wbeat = 0; n_rbeat = 0; n_wfin = 0; n_rfin = 0;
        last_addr = '0;
    endtask

    task automatic queue_burst(input bit is_rd, input int len, input logic [AW-1:0] addr,
                               input logic [DW-1:0] base);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = addr + AW'(i * 8);
            exp_cmd_q.push_back({(is_rd ? APP_CMD_RD : APP_CMD_WR), a});
            if (is_rd) begin
                exp_rdata_q.push_back(ref_mem.exists(a) ? ref_mem[a] : '0);
            end else begin
                exp_wdata_q.push_back(base + DW'(i));
                ref_mem[a] = base + DW'(i);
            end
        end
    endtask

    task automatic run_burst(input int idx, input vec_t v);
        int budget;
        clear_counts();
        queue_burst(v.is_rd, v.len, v.addr, v.base);
        wr_base     = v.base;
        wr_beat_idx = 0;
        @(posedge ui_clk);
        #1;
        if (v.is_rd) begin
            rd_burst_req  = 1'b1;
            rd_burst_len  = LEN_WIDTH'(v.len);
            rd_burst_addr = v.addr;
        end else begin
            wr_burst_req  = 1'b1;
            wr_burst_len  = LEN_WIDTH'(v.len);
            wr_burst_addr = v.addr;
        end
        budget = 0;
        do begin
            @(negedge ui_clk);
            #1;
            budget++;
        end while (n_wfin + n_rfin == 0 && budget < 5000);
        if (budget >= 5000) flag($sformatf("vec%0d_timeout", idx), DW'(budget));
        @(posedge ui_clk);
        #1;
        rd_burst_req = 1'b0;
        wr_burst_req = 1'b0;
        repeat (3) @(negedge ui_clk);
        #1;
        check($sformatf("vec%0d_ncmd", idx), DW'(n_cmd), DW'(v.exp_ncmd));
        if (v.exp_ncmd > 0) check($sformatf("vec%0d_last_addr", idx), DW'(last_addr), DW'(v.exp_last));
        check($sformatf("vec%0d_beats", idx), DW'(v.is_rd ? n_rbeat : n_wbeat), DW'(v.len));
        check($sformatf("vec%0d_fin", idx), DW'({n_rfin[3:0], n_wfin[3:0]}),
              DW'(v.is_rd ? 8'h10 : 8'h01));
        check($sformatf("vec%0d_queues_empty", idx),
              DW'(exp_cmd_q.size() + exp_wdata_q.size() + exp_rdata_q.size()), DW'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst           = 1'b1;
        rd_burst_req  = 1'b0;
        wr_burst_req  = 1'b0;
        rd_burst_len  = '0;
        wr_burst_len  = '0;
        rd_burst_addr = '0;
        wr_burst_addr = '0;
        wr_base       = '0;
        wr_beat_idx   = 0;
        clear_counts();

        //          is_rd len  addr          base        ncmd last
        vecs[0] = '{1'b0, 128, 28'h0000000, 128'h0,   128, 28'h00003F8};
        vecs[1] = '{1'b1, 128, 28'h0000000, 128'h0,   128, 28'h00003F8};
        vecs[2] = '{1'b0, 4,   28'hFFFFFF0, 128'h100, 4,   28'h0000008};
        vecs[3] = '{1'b1, 4,   28'hFFFFFF0, 128'h0,   4,   28'h0000008};
        vecs[4] = '{1'b0, 0,   28'h0000040, 128'h0,   0,   28'h0000000};
        vecs[5] = '{1'b0, 1,   28'h0001000, 128'hAB,  1,   28'h0001000};
        vecs[6] = '{1'b1, 1,   28'h0001000, 128'h0,   1,   28'h0001000};
        vecs[7] = '{1'b1, 3,   28'h0000010, 128'h0,   3,   28'h0000020};

        // reset values
        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        check("rst_app_en", DW'(app_en), DW'(0));
        check("rst_app_cmd", DW'(app_cmd), DW'(3'b001));
        check("rst_app_addr", DW'(app_addr), DW'(0));
        check("rst_rd_valid", DW'(rd_burst_data_valid), DW'(0));
        check("rst_rd_data", rd_burst_data, DW'(0));
        check("rst_finish", DW'({rd_burst_finish, wr_burst_finish}), DW'(0));
        check("rst_state", DW'(dbg_state), DW'(ST_IDLE));
        check("rst_mask", DW'(app_wdf_mask), DW'(0));
        @(posedge ui_clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge ui_clk);

        // table-driven bursts
        for (int i = 0; i < 8; i++) run_burst(i, vecs[i]);

        // zero-length write: finish appears two cycles after the request
        clear_counts();
        @(posedge ui_clk);
        #1;
        wr_burst_req  = 1'b1;
        wr_burst_len  = '0;
        wr_burst_addr = 28'h80;
        n = 0;
        do begin
            @(negedge ui_clk);
            n++;
        end while (!wr_burst_finish && n < 10);
        check("len0_finish_latency", DW'(n - 1), DW'(2));
        @(posedge ui_clk);
        #1;
        wr_burst_req = 1'b0;
        repeat (3) @(negedge ui_clk);
        #1;
        check("len0_no_activity", DW'({n_cmd[7:0], n_wbeat[7:0]}), DW'(0));
        check("len0_one_finish", DW'(n_wfin), DW'(1));

        // simultaneous read and write requests: read first, then write
        clear_counts();
        queue_burst(1'b1, 2, 28'h0, '0);
        queue_burst(1'b0, 2, 28'h2000, 128'h50);
        wr_base     = 128'h50;
        wr_beat_idx = 0;
        @(posedge ui_clk);
        #1;
        rd_burst_req  = 1'b1;
        rd_burst_len  = 10'd2;
        rd_burst_addr = 28'h0;
        wr_burst_req  = 1'b1;
        wr_burst_len  = 10'd2;
        wr_burst_addr = 28'h2000;
        n = 0;
        do begin
            @(negedge ui_clk);
            #1;
            n++;
        end while (n_rfin == 0 && n < 2000);
        check("both_rd_first_fin", DW'({n_rfin[3:0], n_wfin[3:0]}), DW'(8'h10));
        check("both_no_wr_yet", DW'({n_cmd[7:0], n_wbeat[7:0]}), DW'(16'h0200));
        @(posedge ui_clk);
        #1;
        rd_burst_req = 1'b0;
        @(negedge ui_clk);
        check("both_idle_gap", DW'(dbg_state), DW'(ST_IDLE));
        @(negedge ui_clk);
        check("both_wr_start", DW'(dbg_state), DW'(ST_MEM_WRITE));
        n = 0;
        do begin
            @(negedge ui_clk);
            #1;
            n++;
        end while (n_wfin == 0 && n < 2000);
        @(posedge ui_clk);
        #1;
        wr_burst_req = 1'b0;
        repeat (3) @(negedge ui_clk);
        #1;
        check("both_fin", DW'({n_rfin[3:0], n_wfin[3:0]}), DW'(8'h11));
        check("both_beats", DW'({n_rbeat[7:0], n_wbeat[7:0]}), DW'(16'h0202));
        check("both_queues_empty",
              DW'(exp_cmd_q.size() + exp_wdata_q.size() + exp_rdata_q.size()), DW'(0));

        // reset in the middle of a 128-beat read
        clear_counts();
        queue_burst(1'b1, 128, 28'h0, '0);
        @(posedge ui_clk);
        #1;
        rd_burst_req  = 1'b1;
        rd_burst_len  = 10'd128;
        rd_burst_addr = 28'h0;
        n = 0;
        do begin
            @(negedge ui_clk);
            #1;
            n++;
        end while (n_rbeat < 50 && n < 5000);
        check("midrst_reached_beat50", DW'(n_rbeat), DW'(50));
        @(posedge ui_clk);
        #2;
        rst = 1'b1;
        rd_burst_req = 1'b0;
        exp_cmd_q.delete();
        exp_rdata_q.delete();
        mig_waddr_q.delete();
        mig_wdata_q.delete();
        #1;
        check("midrst_app_en", DW'(app_en), DW'(0));
        check("midrst_app_cmd", DW'(app_cmd), DW'(3'b001));
        check("midrst_app_addr", DW'(app_addr), DW'(0));
        check("midrst_rd_valid", DW'(rd_burst_data_valid), DW'(0));
        check("midrst_rd_data", rd_burst_data, DW'(0));
        check("midrst_state", DW'(dbg_state), DW'(ST_IDLE));
        repeat (3) @(posedge ui_clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (pend_q.size() > 0 && n < 200) begin
            @(negedge ui_clk);
            n++;
        end
        repeat (5) @(negedge ui_clk);
        #1;
        check("midrst_late_data_ignored", DW'(n_rbeat), DW'(50));
        check("midrst_no_finish", DW'(n_rfin), DW'(0));
        check("midrst_idle", DW'(dbg_state), DW'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
